// File: rtl/commit_trace_uart_tx.sv
// Commit trace streamer: buffers retired register writes in a FIFO and sends each
// as an 8N1 UART frame (address byte, then data bytes MSB first).
module commit_trace_uart_tx #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned REG_ADDR_WIDTH = 5,
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned CLKS_PER_BIT   = 434
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] i_wr_addr,
  input  logic [DATA_WIDTH-1:0]     i_wr_data,
  output logic                      o_uart_tx,
  output logic                      o_busy,
  output logic                      o_full,
  output logic                      o_overflow
);

  localparam int unsigned NBYTES  = 1 + DATA_WIDTH / 8;
  localparam int unsigned SH_W    = 8 * NBYTES;
  localparam int unsigned ENTRY_W = REG_ADDR_WIDTH + DATA_WIDTH;
  localparam int unsigned PTR_W   = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W   = PTR_W + 1;
  localparam int unsigned BAUD_W  = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned BIDX_W  = $clog2(NBYTES);

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t              r_state, w_state_nxt;
  logic [ENTRY_W-1:0]  r_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]    r_count, w_count_nxt;
  logic [SH_W-1:0]     r_shreg, w_shreg_nxt;
  logic [BAUD_W-1:0]   r_baud, w_baud_nxt;
  logic [2:0]          r_bit_idx, w_bit_nxt;
  logic [BIDX_W-1:0]   r_byte_idx, w_byte_nxt;
  logic                r_tx, w_tx_nxt;
  logic                r_busy, r_full, r_overflow;

  logic                w_push, w_pop, w_drop, w_baud_end;
  logic [ENTRY_W-1:0]  w_head;
  logic [7:0]          w_addr8;
  logic [SH_W-1:0]     w_load;
  logic [7:0]          w_cur_byte;

  // Full is judged on the count before the edge, so a pop never frees room for a same-cycle push
  assign w_push     = i_wr_en && (r_count != CNT_W'(FIFO_DEPTH));
  assign w_drop     = i_wr_en && (r_count == CNT_W'(FIFO_DEPTH));
  assign w_pop      = (r_state == S_IDLE) && (r_count != '0);
  assign w_baud_end = (r_baud == BAUD_W'(CLKS_PER_BIT - 1));
  assign w_head     = r_mem[r_rd_ptr];
  assign w_addr8    = 8'(w_head[ENTRY_W-1:DATA_WIDTH]);
  assign w_load     = {w_addr8, w_head[DATA_WIDTH-1:0]};

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next state plus datapath; the line level is computed from next-state values so it leaves a flop
  always_comb begin
    w_state_nxt = r_state;
    w_baud_nxt  = r_baud + BAUD_W'(1);
    w_bit_nxt   = r_bit_idx;
    w_byte_nxt  = r_byte_idx;
    w_shreg_nxt = r_shreg;
    w_tx_nxt    = 1'b1;
    w_cur_byte  = '0;
    case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (w_pop) begin
          w_state_nxt = S_START;
          w_shreg_nxt = w_load;
          w_byte_nxt  = '0;
        end
      end
      S_START: begin
        if (w_baud_end) begin
          w_state_nxt = S_DATA;
          w_baud_nxt  = '0;
          w_bit_nxt   = '0;
        end
      end
      S_DATA: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) w_state_nxt = S_STOP;
          else                   w_bit_nxt   = r_bit_idx + 3'd1;
        end
      end
      S_STOP: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_byte_idx == BIDX_W'(NBYTES - 1)) begin
            w_state_nxt = S_IDLE;
          end else begin
            w_state_nxt = S_START;
            w_byte_nxt  = r_byte_idx + BIDX_W'(1);
            w_shreg_nxt = r_shreg << 8;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    w_cur_byte = w_shreg_nxt[SH_W-1 -: 8];
    case (w_state_nxt)
      S_START: w_tx_nxt = 1'b0;
      S_DATA:  w_tx_nxt = w_cur_byte[w_bit_nxt];
      default: w_tx_nxt = 1'b1;
    endcase
  end

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {i_wr_addr, i_wr_data};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_shreg    <= '0;
      r_baud     <= '0;
      r_bit_idx  <= '0;
      r_byte_idx <= '0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      r_count    <= w_count_nxt;
      r_shreg    <= w_shreg_nxt;
      r_baud     <= w_baud_nxt;
      r_bit_idx  <= w_bit_nxt;
      r_byte_idx <= w_byte_nxt;
      r_tx       <= w_tx_nxt;
      r_busy     <= (w_state_nxt != S_IDLE) || (w_count_nxt != '0);
      r_full     <= (w_count_nxt == CNT_W'(FIFO_DEPTH));
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  assign o_uart_tx  = r_tx;
  assign o_busy     = r_busy;
  assign o_full     = r_full;
  assign o_overflow = r_overflow;

endmodule

// File: tb/tb_commit_trace_uart_tx.sv
// Directed bench for commit_trace_uart_tx: a 32-bit/depth-4/4-clk-per-bit instance and
// an 8-bit/depth-2/1-clk-per-bit instance, decoding the serial line cycle by cycle.
module tb_commit_trace_uart_tx;

  logic        clk = 1'b0;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;
  int          stop_err = 0;
  int          to_err = 0;

  logic        rst_a, wr_en_a, tx_a, busy_a, full_a, ovf_a;
  logic [4:0]  addr_a;
  logic [31:0] data_a;
  logic        rst_b, wr_en_b, tx_b, busy_b, full_b, ovf_b;
  logic [4:0]  addr_b;
  logic [7:0]  data_b;

  commit_trace_uart_tx #(.DATA_WIDTH(32), .REG_ADDR_WIDTH(5), .FIFO_DEPTH(4), .CLKS_PER_BIT(4)) u_a (
    .clk(clk), .rst(rst_a), .i_wr_en(wr_en_a), .i_wr_addr(addr_a), .i_wr_data(data_a),
    .o_uart_tx(tx_a), .o_busy(busy_a), .o_full(full_a), .o_overflow(ovf_a));

  commit_trace_uart_tx #(.DATA_WIDTH(8), .REG_ADDR_WIDTH(5), .FIFO_DEPTH(2), .CLKS_PER_BIT(1)) u_b (
    .clk(clk), .rst(rst_b), .i_wr_en(wr_en_b), .i_wr_addr(addr_b), .i_wr_data(data_b),
    .o_uart_tx(tx_b), .o_busy(busy_b), .o_full(full_b), .o_overflow(ovf_b));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  function automatic logic line(input int w);
    return (w == 0) ? tx_a : tx_b;
  endfunction

  function automatic logic busyf(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction

  // Sample each bit mid-cell; t_known >= 0 gives the start-bit cycle instead of searching for it
  task automatic rx_byte(input int w, input int t_known, output logic [7:0] b, output int t0);
    int c;
    bit got;
    c   = (w == 0) ? 4 : 1;
    b   = '0;
    got = 1'b0;
    t0  = t_known;
    if (t_known < 0) begin
      for (int k = 0; k < 3000 && !got; k++) begin
        @(negedge clk);
        if (line(w) == 1'b0) begin
          got = 1'b1;
          t0  = cyc;
        end
      end
      if (!got) begin
        to_err++;
        return;
      end
    end
    for (int i = 0; i < 8; i++) begin
      while (cyc < t0 + c * (i + 1) + c / 2) @(negedge clk);
      b[i] = line(w);
    end
    while (cyc < t0 + 9 * c + c / 2) @(negedge clk);
    if (line(w) !== 1'b1) stop_err++;
  endtask

  task automatic rx_frame(input int w, input int nb, input int t_known, output logic [39:0] fr, output int t0);
    logic [7:0] b;
    int ts;
    fr = '0;
    t0 = -1;
    for (int k = 0; k < nb; k++) begin
      rx_byte(w, (k == 0) ? t_known : -1, b, ts);
      if (k == 0) t0 = ts;
      fr = {fr[31:0], b};
    end
  endtask

  // Busy must still be high on the last frame cycle and low on the first cycle after it
  task automatic chk_end(input string tag, input int w, input int t0, input int len);
    while (cyc < t0 + len - 1) @(negedge clk);
    chk({tag, "_busy_last"}, 64'(busyf(w)), 64'd1);
    @(negedge clk);
    chk({tag, "_busy_after"}, 64'(busyf(w)), 64'd0);
    chk({tag, "_line_after"}, 64'(line(w)), 64'd1);
  endtask

  initial begin
    logic [39:0] fr;
    int t0, t_prev, ce, bad;
    rst_a = 1'b1; wr_en_a = 1'b0; addr_a = '0; data_a = '0;
    rst_b = 1'b1; wr_en_b = 1'b0; addr_b = '0; data_b = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", 64'(tx_a), 64'd1);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_full", 64'(full_a), 64'd0);
    chk("rst_ovf", 64'(ovf_a), 64'd0);
    rst_a = 1'b0;
    rst_b = 1'b0;

    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if ({tx_a, busy_a, full_a, ovf_a} !== 4'b1000) bad++;
    end
    chk("idle_100", 64'(bad), 64'd0);

    // Single commit
    stop_err = 0; to_err = 0;
    wr_en_a = 1'b1; addr_a = 5'd5; data_a = 32'hDEADBEEF;
    @(negedge clk);
    ce = cyc;
    wr_en_a = 1'b0;
    chk("one_busy_capt", 64'(busy_a), 64'd1);
    chk("one_line_capt", 64'(tx_a), 64'd1);
    rx_frame(0, 5, -1, fr, t0);
    chk("one_start_lat", 64'(t0), 64'(ce + 1));
    chk("one_frame", 64'(fr), 64'h05DEADBEEF);
    chk_end("one", 0, t0, 200);
    chk("one_stop_to", 64'(stop_err + to_err), 64'd0);

    // Six back-to-back commits into a depth-4 FIFO: 1 pops at once, 2..5 fill it, 6 drops
    stop_err = 0; to_err = 0;
    for (int i = 1; i <= 6; i++) begin
      wr_en_a = 1'b1; addr_a = 5'(i); data_a = 32'hC0DE0000 | 32'(i);
      @(negedge clk);
      if (i == 1) ce = cyc;
      if (i == 4) chk("burst_full_c4", 64'(full_a), 64'd0);
      if (i == 5) begin
        chk("burst_full_c5", 64'(full_a), 64'd1);
        chk("burst_ovf_c5", 64'(ovf_a), 64'd0);
      end
      if (i == 6) chk("burst_ovf_c6", 64'(ovf_a), 64'd1);
    end
    wr_en_a = 1'b0;
    t_prev = 0;
    for (int i = 1; i <= 5; i++) begin
      rx_frame(0, 5, (i == 1) ? ce + 1 : -1, fr, t0);
      chk($sformatf("burst_frame%0d", i), 64'(fr), {24'd0, 8'(i), 32'hC0DE0000 | 32'(i)});
      if (i > 1) chk($sformatf("burst_gap%0d", i), 64'(t0 - t_prev), 64'd201);
      t_prev = t0;
    end
    chk_end("burst", 0, t0, 200);
    chk("burst_ovf_sticky", 64'(ovf_a), 64'd1);
    chk("burst_stop_to", 64'(stop_err + to_err), 64'd0);

    // Push while full at the same edge as an IDLE->START pop
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("clr_ovf", 64'(ovf_a), 64'd0);
    for (int i = 0; i < 5; i++) begin
      wr_en_a = 1'b1; addr_a = 5'(10 + i); data_a = 32'h11110000 | 32'(i);
      @(negedge clk);
      if (i == 0) ce = cyc;
    end
    wr_en_a = 1'b0;
    t0 = ce + 1;
    while (cyc < t0 + 200) @(negedge clk);
    chk("pp_full_pre", 64'(full_a), 64'd1);
    chk("pp_ovf_pre", 64'(ovf_a), 64'd0);
    wr_en_a = 1'b1; addr_a = 5'd15; data_a = 32'hFFFFFFFF;
    @(negedge clk);
    wr_en_a = 1'b0;
    chk("pp_ovf_post", 64'(ovf_a), 64'd1);
    chk("pp_full_post", 64'(full_a), 64'd0);
    chk("pp_count_post", 64'(u_a.r_count), 64'd3);
    chk("pp_start_bit", 64'(tx_a), 64'd0);

    // Reset during a data bit of byte 2 with three entries queued
    t0 = cyc;
    while (cyc < t0 + 90) @(negedge clk);
    rst_a = 1'b1;
    @(negedge clk);
    rst_a = 1'b0;
    chk("mrst_tx", 64'(tx_a), 64'd1);
    chk("mrst_busy", 64'(busy_a), 64'd0);
    chk("mrst_full", 64'(full_a), 64'd0);
    chk("mrst_ovf", 64'(ovf_a), 64'd0);
    bad = 0;
    repeat (300) begin
      @(negedge clk);
      if ({tx_a, busy_a} !== 2'b10) bad++;
    end
    chk("mrst_quiet", 64'(bad), 64'd0);
    stop_err = 0; to_err = 0;
    wr_en_a = 1'b1; addr_a = 5'd9; data_a = 32'h01234567;
    @(negedge clk);
    ce = cyc;
    wr_en_a = 1'b0;
    rx_frame(0, 5, -1, fr, t0);
    chk("mrst_start_lat", 64'(t0), 64'(ce + 1));
    chk("mrst_frame", 64'(fr), 64'h0901234567);
    chk_end("mrst", 0, t0, 200);
    chk("mrst_stop_to", 64'(stop_err + to_err), 64'd0);

    // One clock per bit, 8-bit data
    stop_err = 0; to_err = 0;
    wr_en_b = 1'b1; addr_b = 5'h1F; data_b = 8'hA5;
    @(negedge clk);
    ce = cyc;
    wr_en_b = 1'b0;
    rx_frame(1, 2, -1, fr, t0);
    chk("fast_start_lat", 64'(t0), 64'(ce + 1));
    chk("fast_frame", 64'(fr), 64'h1FA5);
    chk_end("fast", 1, t0, 20);
    chk("fast_stop_to", 64'(stop_err + to_err), 64'd0);
    chk("fast_ovf", 64'(ovf_b), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
